// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

  // Controller modes: normal issue, multiply/divide in flight, core stopped.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } hc_state_t;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 16;
  localparam int DEF_CNT_W      = 5;

  // Architectural register number (R0..R15).
  typedef logic [3:0] reg_num_t;

  // Preload for the MD down-counter: the start cycle and the write-back
  // cycle are not counted, hence the -2.
  function automatic int md_preload(input logic is_div, input int mul_cycles,
                                    input int div_cycles);
    return (is_div ? div_cycles : mul_cycles) - 2;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic        id_valid;
  reg_num_t    id_op1;
  reg_num_t    id_op2;
  logic        id_use1;
  logic        id_use2;
  logic        id_branch;
  logic        branch_taken;
  logic        id_muldiv;
  logic        id_is_div;
  logic        id_halt;
  logic        ex_memread;
  reg_num_t    ex_wreg;

  logic        stall;
  logic        bubble;
  logic        flush;
  logic        md_start;
  logic        md_div;
  logic        md_wb;
  logic        halted;
  logic [15:0] stall_cycles;

  // Pipeline side: presents ID/EX status, consumes the controls.
  modport master (
    output id_valid, id_op1, id_op2, id_use1, id_use2, id_branch,
           branch_taken, id_muldiv, id_is_div, id_halt, ex_memread, ex_wreg,
    input  stall, bubble, flush, md_start, md_div, md_wb, halted, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_valid, id_op1, id_op2, id_use1, id_use2, id_branch,
           branch_taken, id_muldiv, id_is_div, id_halt, ex_memread, ex_wreg,
    output stall, bubble, flush, md_start, md_div, md_wb, halted, stall_cycles
  );

endinterface

// File: rtl/hazard_md_counter.sv
// Loadable down-counter tracking the remaining busy cycles of the MD unit.
module hazard_md_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush, MD sequencing, halt,
// and a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  hc_state_t        state_reg;
  hc_state_t        state_next;
  logic [15:0]      stall_cnt_reg;

  reg_num_t         src_op [2];
  logic [1:0]       src_use;
  logic [1:0]       src_hit;
  logic             load_use;

  logic             stall_c;
  logic             bubble_c;
  logic             flush_c;
  logic             start_c;
  logic             div_c;
  logic             wb_c;
  logic             halted_c;

  logic             md_zero;
  logic             md_dec;
  logic [CNT_W-1:0] md_load_val;

  assign src_op[0] = bus.id_op1;
  assign src_op[1] = bus.id_op2;
  assign src_use   = {bus.id_use2, bus.id_use1};

  // One comparator per source operand against the load's destination (R0 too).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (bus.ex_wreg == src_op[gi]);
    end
  endgenerate

  assign load_use = bus.ex_memread && bus.id_valid && (|src_hit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; ID inputs only matter while in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (load_use) begin
          state_next = RUN;
        end else if (bus.id_valid && bus.id_halt) begin
          state_next = HALT;
        end else if (bus.id_valid && bus.id_muldiv) begin
          state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_zero) begin
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    start_c  = 1'b0;
    div_c    = 1'b0;
    wb_c     = 1'b0;
    halted_c = 1'b0;
    case (state_reg)
      RUN: begin
        if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (bus.id_valid && bus.id_halt) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (bus.id_valid && bus.id_muldiv) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          start_c  = 1'b1;
          div_c    = bus.id_is_div;
        end else if (bus.id_valid && bus.id_branch && bus.branch_taken) begin
          flush_c  = 1'b1;
        end
      end
      MD_BUSY: begin
        // The MD instruction retires through md_wb and never enters EX.
        bubble_c = 1'b1;
        if (md_zero) begin
          wb_c    = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      HALT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        halted_c = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      start_c  = 1'b0;
      div_c    = 1'b0;
      wb_c     = 1'b0;
      halted_c = 1'b0;
    end
  end

  assign md_load_val = CNT_W'(md_preload(bus.id_is_div, MUL_CYCLES, DIV_CYCLES));
  assign md_dec      = (state_reg == MD_BUSY) && !md_zero;

  hazard_md_counter #(
    .CNT_W (CNT_W)
  ) u_md_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (start_c),
    .load_val (md_load_val),
    .dec      (md_dec),
    .zero     (md_zero)
  );

  // Count stalled cycles outside HALT, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_c && (state_reg != HALT) && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.bubble       = bubble_c;
  assign bus.flush        = flush_c;
  assign bus.md_start     = start_c;
  assign bus.md_div       = div_c;
  assign bus.md_wb        = wb_c;
  assign bus.halted       = halted_c;
  assign bus.stall_cycles = rst ? 16'd0 : stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences and
// randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       use1;
    logic       use2;
    logic       branch;
    logic       taken;
    logic       muldiv;
    logic       is_div;
    logic       halt;
    logic       memread;
    logic [3:0] wreg;
  } in_t;

  // Control vector order: {stall, bubble, flush, md_start, md_div, md_wb, halted}
  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: halted flag, cycles left until MD write-back, stall count.
  bit m_halted;
  int m_busy;
  int m_cnt;

  function automatic in_t idle();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic logic m_load_use(input in_t x);
    return x.memread && x.valid &&
           ((x.use1 && (x.wreg == x.op1)) || (x.use2 && (x.wreg == x.op2)));
  endfunction

  function automatic logic [6:0] model_ctl(input in_t x);
    if (x.rst)            return 7'b0000000;
    if (m_halted)         return 7'b1100001;
    if (m_busy > 0)       return (m_busy == 1) ? 7'b0100010 : 7'b1100000;
    if (m_load_use(x))    return 7'b1100000;
    if (x.valid && x.halt)   return 7'b1100000;
    if (x.valid && x.muldiv) return {4'b1101, x.is_div, 2'b00};
    if (x.valid && x.branch && x.taken) return 7'b0010000;
    return 7'b0000000;
  endfunction

  task automatic model_update(input in_t x);
    logic [6:0] c;
    c = model_ctl(x);
    if (x.rst) begin
      m_halted = 1'b0;
      m_busy   = 0;
      m_cnt    = 0;
    end else begin
      if (c[6] && !m_halted && (m_cnt < 65535)) m_cnt++;
      if (m_halted) begin
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (!m_load_use(x) && x.valid && x.halt) begin
        m_halted = 1'b1;
      end else if (!m_load_use(x) && x.valid && x.muldiv) begin
        m_busy = (x.is_div ? DIV_N : MUL_N) - 1;
      end
    end
  endtask

  task automatic drive(input in_t x);
    rst              = x.rst;
    bus.id_valid     = x.valid;
    bus.id_op1       = x.op1;
    bus.id_op2       = x.op2;
    bus.id_use1      = x.use1;
    bus.id_use2      = x.use2;
    bus.id_branch    = x.branch;
    bus.branch_taken = x.taken;
    bus.id_muldiv    = x.muldiv;
    bus.id_is_div    = x.is_div;
    bus.id_halt      = x.halt;
    bus.ex_memread   = x.memread;
    bus.ex_wreg      = x.wreg;
  endtask

  // One clock: drive at posedge+1, sample at posedge+4, then advance the model.
  task automatic step(input in_t x, input logic [6:0] exp, input bit hard,
                      input string name);
    logic [6:0]  act;
    logic [6:0]  mexp;
    logic [15:0] exp_cnt;
    drive(x);
    #3;
    act     = {bus.stall, bus.bubble, bus.flush, bus.md_start, bus.md_div,
               bus.md_wb, bus.halted};
    mexp    = model_ctl(x);
    exp_cnt = x.rst ? 16'd0 : 16'(m_cnt);
    checks++;
    if (act !== mexp) begin
      errors++;
      $display("FAIL ctl_model %s: got %b required %b", name, act, mexp);
    end
    if (hard) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL ctl_vec %s: got %b required %b", name, act, exp);
      end
      $display("vec %-12s ctl=%b stall_cycles=%0d", name, act, bus.stall_cycles);
    end
    checks++;
    if (bus.stall_cycles !== exp_cnt) begin
      errors++;
      $display("FAIL stall_cycles %s: got %0d required %0d", name,
               bus.stall_cycles, exp_cnt);
    end
    @(posedge clk);
    model_update(x);
    #1;
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (bus.stall_cycles !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, bus.stall_cycles, exp);
    end else begin
      $display("vec %-12s stall_cycles=%0d", name, bus.stall_cycles);
    end
  endtask

  function automatic in_t mk(input logic valid, input logic [3:0] op1,
                             input logic use1, input logic [3:0] op2,
                             input logic use2, input logic branch,
                             input logic taken, input logic memread,
                             input logic [3:0] wreg);
    in_t x;
    x         = idle();
    x.valid   = valid;
    x.op1     = op1;
    x.use1    = use1;
    x.op2     = op2;
    x.use2    = use2;
    x.branch  = branch;
    x.taken   = taken;
    x.memread = memread;
    x.wreg    = wreg;
    return x;
  endfunction

  vec_t tab [11];

  initial begin
    in_t x;
    in_t r;
    int  cnt0;

    m_halted = 1'b0;
    m_busy   = 0;
    m_cnt    = 0;
    r        = idle();
    r.rst    = 1'b1;
    drive(r);
    @(posedge clk);
    #1;

    // Vector table: all rows leave the controller in RUN.
    tab[0]  = '{mk(0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 4'd0), 7'b0000000, "idle"};
    tab[1]  = '{mk(1, 4'd1, 0, 4'd3, 1, 0, 0, 1, 4'd3), 7'b1100000, "lu_op2"};
    tab[2]  = '{mk(1, 4'd1, 0, 4'd3, 0, 0, 0, 1, 4'd3), 7'b0000000, "lu_op2_nouse"};
    tab[3]  = '{mk(1, 4'd0, 1, 4'd7, 0, 0, 0, 1, 4'd0), 7'b1100000, "lu_r0"};
    tab[4]  = '{mk(1, 4'd2, 0, 4'd4, 0, 1, 1, 0, 4'd0), 7'b0010000, "br_taken"};
    tab[5]  = '{mk(1, 4'd2, 0, 4'd4, 0, 1, 0, 0, 4'd0), 7'b0000000, "br_not"};
    tab[6]  = '{mk(0, 4'd2, 0, 4'd4, 0, 1, 1, 0, 4'd0), 7'b0000000, "br_novalid"};
    tab[7]  = '{mk(0, 4'd5, 1, 4'd5, 1, 0, 0, 1, 4'd5), 7'b0000000, "lu_novalid"};
    tab[8]  = '{mk(1, 4'd5, 1, 4'd6, 1, 0, 0, 1, 4'd9), 7'b0000000, "lu_nomatch"};
    tab[9]  = '{mk(1, 4'd5, 1, 4'd6, 1, 0, 0, 0, 4'd5), 7'b0000000, "no_memread"};
    tab[10] = '{mk(1, 4'd8, 1, 4'd1, 0, 1, 1, 1, 4'd8), 7'b1100000, "lu_op1_br"};

    step(r, 7'b0000000, 1, "reset");
    step(idle(), 7'b0000000, 1, "post_reset");
    for (int i = 0; i < 11; i++) begin
      step(tab[i].in, tab[i].exp, 1, tab[i].name);
    end

    // MUL: start, two busy stalls, write-back, back in RUN.
    cnt0     = m_cnt;
    x        = idle();
    x.valid  = 1'b1;
    x.muldiv = 1'b1;
    step(x, 7'b1101000, 1, "mul_c1");
    step(x, 7'b1100000, 1, "mul_c2");
    step(x, 7'b1100000, 1, "mul_c3");
    step(x, 7'b0100010, 1, "mul_c4");
    step(idle(), 7'b0000000, 1, "mul_c5");
    check_cnt("mul_stalls", 16'(cnt0 + 3));

    // DIV interrupted by reset in busy cycle 7.
    x.is_div = 1'b1;
    step(x, 7'b1101100, 1, "div_c1");
    for (int k = 2; k <= 6; k++) step(x, 7'b1100000, 1, "div_busy");
    step(r, 7'b0000000, 1, "div_rst");
    for (int k = 0; k < 18; k++) step(idle(), 7'b0000000, 1, "div_after");
    check_cnt("div_rst_cnt", 16'd0);

    // Taken branch colliding with load-use on op1.
    x = mk(1, 4'd5, 1, 4'd0, 0, 1, 1, 1, 4'd5);
    step(x, 7'b1100000, 1, "brlu_c1");
    x.memread = 1'b0;
    step(x, 7'b0010000, 1, "brlu_c2");
    step(idle(), 7'b0000000, 1, "brlu_c3");

    // HALT: halted next cycle, counter frozen, MD requests ignored.
    x       = idle();
    x.valid = 1'b1;
    x.halt  = 1'b1;
    step(x, 7'b1100000, 1, "halt_dec");
    cnt0     = m_cnt;
    x        = idle();
    x.valid  = 1'b1;
    x.muldiv = 1'b1;
    for (int k = 0; k < 4; k++) step(x, 7'b1100001, 1, "halt_ign");
    check_cnt("halt_frozen", 16'(cnt0));
    step(r, 7'b0000000, 1, "halt_rst");
    step(idle(), 7'b0000000, 1, "halt_exit");

    // Saturation of the stall counter.
    x = mk(1, 4'd3, 1, 4'd0, 0, 0, 0, 1, 4'd3);
    for (int k = 0; k < 65540; k++) step(x, 7'b1100000, 0, "sat");
    check_cnt("saturate", 16'hFFFF);
    step(x, 7'b1100000, 1, "sat_hold");
    check_cnt("saturate2", 16'hFFFF);
    step(r, 7'b0000000, 1, "sat_rst");

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      x         = idle();
      x.rst     = ($urandom_range(63) == 0);
      x.valid   = ($urandom_range(3) != 0);
      x.op1     = 4'($urandom_range(3));
      x.op2     = 4'($urandom_range(3));
      x.use1    = 1'($urandom_range(1));
      x.use2    = 1'($urandom_range(1));
      x.branch  = 1'($urandom_range(1));
      x.taken   = 1'($urandom_range(1));
      x.muldiv  = ($urandom_range(7) == 0);
      x.is_div  = 1'($urandom_range(1));
      x.halt    = ($urandom_range(31) == 0);
      x.memread = ($urandom_range(2) == 0);
      x.wreg    = 4'($urandom_range(3));
      step(x, 7'b0000000, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
